traffic_controller: RTL
=======================

TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter GREEN_T, default 4'd15, SHALL be the NS green timer code (the timer maps 15 to 21 cycles).
REQ-003 Parameter EW_GREEN_T, default 4'd10, SHALL be the EW green timer code.
REQ-004 Parameter YELLOW_T, default 4'd4, SHALL be the yellow timer code for both directions.
REQ-005 Port Clk, input, 1: rising-edge clock.
REQ-006 Port Rst, input, 1: synchronous active-high reset.
REQ-007 Port TDone, input, 1: timer expired flag, registered by the downstream timer.
REQ-008 Port Sensor, input, 1: EW vehicle-present pulse or level.
REQ-009 Port TimerD, output, 4: timer load value.
REQ-010 Port TimerEn, output, 1: timer enable, where 0 loads TimerD and 1 counts.
REQ-011 Port Phase, output, 2: current phase code, feeding the lamp decoder select.
REQ-012 Port CarPending, output, 1: latched EW request.

Function
REQ-013 Phases SHALL be encoded NS_GREEN=00, NS_YELLOW=01, EW_GREEN=10, EW_YELLOW=11; Phase SHALL equal the state register directly.
REQ-014 Each phase SHALL have two sub-steps, LOAD (one cycle) and RUN.
REQ-015 TimerEn SHALL be 0 in LOAD and 1 in RUN, decoded combinationally from the sub-step register.
REQ-016 TimerD SHALL be the duration for the current phase in every cycle: NS_GREEN=GREEN_T, EW_GREEN=EW_GREEN_T, yellows=YELLOW_T.
REQ-017 LOAD SHALL always go to RUN on the next edge; TDone SHALL be ignored in LOAD because it is stale.
REQ-018 In RUN with TDone=1, the block SHALL advance to the next phase's LOAD on the next edge.
REQ-019 In RUN with TDone=0, the block SHALL hold.
REQ-020 The phase order SHALL be NS_GREEN -> NS_YELLOW -> EW_GREEN -> EW_YELLOW -> NS_GREEN, wrapping modulo 4.
REQ-021 CarPending SHALL set on any cycle with Sensor=1.
REQ-022 CarPending SHALL clear on the edge entering EW_GREEN LOAD.
REQ-023 If Sensor=1 on that same edge, set SHALL win and CarPending SHALL stay 1.
REQ-024 Lamp outputs SHALL never show two greens at once; yellow SHALL always precede a change of direction.

Reset
REQ-025 With Rst=1 at an edge, the block SHALL set Phase=00, sub-step=LOAD, and CarPending=0.
REQ-026 While Rst=1, outputs SHALL be TimerEn=0 and TimerD=GREEN_T, so the timer is reloaded every cycle.
REQ-027 Rst asserted mid-phase SHALL abandon the phase on the next edge with no partial timing retained.
REQ-028 After Rst deasserts, the first cycle SHALL be NS_GREEN LOAD.

Configuration
REQ-029 With macro TLC_SENSOR_EN defined: in NS_GREEN RUN with TDone=1 and CarPending=0, the block SHALL go to NS_GREEN LOAD, so NS green re-arms.
REQ-030 With TLC_SENSOR_EN defined: in NS_GREEN RUN with TDone=1 and CarPending=1, the block SHALL go to NS_YELLOW.
REQ-031 Without TLC_SENSOR_EN: the phase sequence SHALL be fixed, Sensor SHALL still latch into CarPending for observation only, and port lists SHALL be identical in both builds.

Structure
REQ-032 A shared package SHALL hold the phase codes, the LOAD/RUN sub-step codes, and the default duration constants.
REQ-033 The CarPending set/clear latch SHALL be a sub-module named req_latch (inputs Clk, Rst, Set, Clr; output Q; set-dominant).
REQ-034 The FSM and output decode SHALL be in traffic_controller itself.

Verification
REQ-035 Reset: hold Rst=1 for 3 cycles -> Phase=00, TimerEn=0, TimerD=15, CarPending=0 on every one of those cycles.
REQ-036 Fixed cycle (macro off), closed loop with the team timer: NS_GREEN lasts 1 load cycle + 21 run cycles, then Phase=01 with TimerD=4, then Phase=10 with TimerD=10, then 11, then wraps to 00.
REQ-037 Stale TDone: hold TDone=1 through a LOAD cycle -> the block still enters RUN and does not skip the phase.
REQ-038 Sensor (macro on): with Sensor=0 always, Phase stays 00 through 3 consecutive TDone events; pulse Sensor=1 for one cycle -> next TDone gives Phase=01, and CarPending drops on entry to 10.
REQ-039 Simultaneous set and clear: Sensor=1 on the edge entering EW_GREEN LOAD -> CarPending stays 1.
REQ-040 Reset mid-operation: assert Rst in EW_YELLOW RUN -> next cycle Phase=00, TimerEn=0.

Source files
------------

// File: rtl/traffic_controller_pkg.sv
// Shared phase/sub-step codes and default timer codes for the traffic light controller.
package traffic_controller_pkg;

   typedef enum logic [1:0] {
      PH_NS_GREEN  = 2'b00,
      PH_NS_YELLOW = 2'b01,
      PH_EW_GREEN  = 2'b10,
      PH_EW_YELLOW = 2'b11
   } phase_e;

   typedef enum logic {
      STEP_LOAD = 1'b0,
      STEP_RUN  = 1'b1
   } step_e;

   localparam logic [3:0] GREEN_T_DEF    = 4'd15;
   localparam logic [3:0] EW_GREEN_T_DEF = 4'd10;
   localparam logic [3:0] YELLOW_T_DEF   = 4'd4;

   // Fixed rotation; the 2-bit code wraps naturally from EW_YELLOW to NS_GREEN.
   function automatic phase_e next_phase(input phase_e ph);
      logic [1:0] nxt;
      nxt = ph + 2'd1;
      return phase_e'(nxt);
   endfunction

   function automatic logic [3:0] phase_duration(
      input phase_e     ph,
      input logic [3:0] ns_green,
      input logic [3:0] ew_green,
      input logic [3:0] yellow
   );
      logic [3:0] dur;
      case (ph)
         PH_NS_GREEN: dur = ns_green;
         PH_EW_GREEN: dur = ew_green;
         default:     dur = yellow;
      endcase
      return dur;
   endfunction

endpackage

// File: rtl/traffic_controller_req_latch.sv
// Set-dominant request latch holding the EW vehicle request until EW green is entered.
module req_latch (
   input  logic Clk,
   input  logic Rst,
   input  logic Set,
   input  logic Clr,
   output logic Q
);

   logic q_q;

   // Reset beats everything; a new request beats the clear on the same edge.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         q_q <= 1'b0;
      end else if (Set) begin
         q_q <= 1'b1;
      end else if (Clr) begin
         q_q <= 1'b0;
      end
   end

   assign Q = q_q;

endmodule

// File: rtl/traffic_controller.sv
// Two-direction traffic light FSM driving an external load/count timer.
// Optional macro TLC_SENSOR_EN: NS green re-arms until an EW request is pending.
module traffic_controller
   import traffic_controller_pkg::*;
#(
   parameter logic [3:0] GREEN_T    = GREEN_T_DEF,
   parameter logic [3:0] EW_GREEN_T = EW_GREEN_T_DEF,
   parameter logic [3:0] YELLOW_T   = YELLOW_T_DEF
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       TDone,
   input  logic       Sensor,
   output logic [3:0] TimerD,
   output logic       TimerEn,
   output logic [1:0] Phase,
   output logic       CarPending
);

   phase_e phase_q, phase_d;
   step_e  step_q,  step_d;
   logic   enter_ew_green;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         phase_q <= PH_NS_GREEN;
         step_q  <= STEP_LOAD;
      end else begin
         phase_q <= phase_d;
         step_q  <= step_d;
      end
   end

   // TDone is only trusted in RUN; during LOAD it still reflects the previous phase.
   always_comb begin
      phase_d = phase_q;
      step_d  = step_q;
      case (step_q)
         STEP_LOAD: begin
            step_d = STEP_RUN;
         end
         STEP_RUN: begin
            if (TDone) begin
               step_d = STEP_LOAD;
`ifdef TLC_SENSOR_EN
               if (phase_q == PH_NS_GREEN && !CarPending) begin
                  phase_d = PH_NS_GREEN;
               end else begin
                  phase_d = next_phase(phase_q);
               end
`else
               phase_d = next_phase(phase_q);
`endif
            end
         end
         default: begin
            step_d = STEP_LOAD;
         end
      endcase
   end

   assign enter_ew_green = !Rst && (step_q == STEP_RUN) && TDone
                           && (phase_q == PH_NS_YELLOW);

   req_latch u_req_latch (
      .Clk (Clk),
      .Rst (Rst),
      .Set (Sensor),
      .Clr (enter_ew_green),
      .Q   (CarPending)
   );

   // Reset forces a reload of the NS green code every cycle it is held.
   assign Phase   = phase_q;
   assign TimerEn = !Rst && (step_q == STEP_RUN);
   assign TimerD  = Rst ? GREEN_T
                        : phase_duration(phase_q, GREEN_T, EW_GREEN_T, YELLOW_T);

endmodule
